// File: rtl/eareeg_seq_gen.sv
// earEEG readout sequence generator: produces fdata/fch/fadc/load/read
// control strobes for a multi-channel frame and serialises an optional
// PREVIN code into channel 0 of the next frame.
//
// state | meaning
// IDLE  | sequencer stopped, counters and control outputs held at 0
// RUN   | frames generated continuously, injections may start
// DRAIN | stop requested, current frame finishes, then back to IDLE
module eareeg_seq_gen #(
  parameter int N_CH   = 4,
  parameter int CODE_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic                      sys_clk,
  input  logic                      rst_n,
  input  logic                      run_trig,
  input  logic                      previn_trig,
  input  logic [CODE_W-1:0]         previn_code,
  input  logic [DIV_W-1:0]          half_div,
  input  logic [$clog2(N_CH):0]     ch_count,
  output logic [4:0]                ctrl_out,
  output logic                      previn_out,
  output logic [$clog2(N_CH)-1:0]   ch_idx,
  output logic                      running,
  output logic                      frame_done
);

  localparam int CH_W   = $clog2(N_CH);
  localparam int CNT_W  = CH_W + 1;
  localparam int SLOT_W = $clog2(CODE_W);
  localparam logic [CNT_W-1:0]  NCH_C     = CNT_W'(N_CH);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CODE_W - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  state_t state, state_nxt;

  logic [1:0]        run_sync, pv_sync;
  logic              run_prev, pv_prev, run_edge, pv_edge;
  logic [2:0]        warm;
  logic [DIV_W-1:0]  half_q, div_cnt;
  logic [CNT_W-1:0]  chn_q, chn_in;
  logic              fdata, fch, fadc, started;
  logic [SLOT_W-1:0] slot, inj_cnt;
  logic [CH_W-1:0]   ch;
  logic              armed, injecting;
  logic [CODE_W-1:0] shift;
  logic              tick, rise, slot_last, ch_last, frame_end, inj_start, stop_now;

  assign tick      = (state != IDLE) && (div_cnt == half_q);
  assign rise      = tick && !fdata;
  assign slot_last = (slot == SLOT_LAST);
  assign ch_last   = ({1'b0, ch} == chn_q - CNT_W'(1));
  assign frame_end = rise && started && slot_last && ch_last;
  assign inj_start = rise && (state == RUN) && armed && (!started || frame_end);
  assign stop_now  = (state == DRAIN) && frame_end;

  // Synchronise triggers; warm-up keeps a level held through reset from looking like an edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      run_sync <= '0;
      pv_sync  <= '0;
      run_prev <= 1'b0;
      pv_prev  <= 1'b0;
      warm     <= '0;
      run_edge <= 1'b0;
      pv_edge  <= 1'b0;
    end else begin
      run_sync <= {run_sync[0], run_trig};
      pv_sync  <= {pv_sync[0], previn_trig};
      run_prev <= run_sync[1];
      pv_prev  <= pv_sync[1];
      warm     <= {warm[1:0], 1'b1};
      run_edge <= warm[2] & run_sync[1] & ~run_prev;
      pv_edge  <= warm[2] & pv_sync[1] & ~pv_prev;
    end
  end

  // Clamp out-of-range channel counts to the full frame.
  always_comb begin
    chn_in = ch_count;
    if (ch_count == '0 || ch_count > NCH_C) chn_in = NCH_C;
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state; run edges during DRAIN are deliberately dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run_edge)  state_nxt = RUN;
      RUN:     if (run_edge)  state_nxt = DRAIN;
      DRAIN:   if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Divider, slot and channel counters; cleared while idle and on the drain frame end.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q  <= '0;
      chn_q   <= '0;
      div_cnt <= '0;
      fdata   <= 1'b0;
      started <= 1'b0;
      slot    <= '0;
      ch      <= '0;
      fch     <= 1'b0;
      fadc    <= 1'b0;
    end else if (state == IDLE || stop_now) begin
      div_cnt <= '0;
      fdata   <= 1'b0;
      started <= 1'b0;
      slot    <= '0;
      ch      <= '0;
      fch     <= 1'b0;
      fadc    <= 1'b0;
      if (state == IDLE && run_edge) begin
        half_q <= half_div;
        chn_q  <= chn_in;
      end
    end else begin
      if (tick) begin
        div_cnt <= '0;
        fdata   <= ~fdata;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (rise) begin
        started <= 1'b1;
        if (started) begin
          if (slot_last) begin
            slot <= '0;
            fch  <= ~fch;
            if (ch_last) begin
              ch   <= '0;
              fadc <= ~fadc;
            end else begin
              ch <= ch + CH_W'(1);
            end
          end else begin
            slot <= slot + SLOT_W'(1);
          end
        end
      end
    end
  end

  // PREVIN injector: arm on edge when free, shift MSB-first one bit per slot.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      injecting <= 1'b0;
      inj_cnt   <= '0;
      shift     <= '0;
    end else begin
      if (pv_edge && !armed && !injecting) begin
        shift <= previn_code;
        armed <= 1'b1;
      end
      if (inj_start) begin
        injecting <= 1'b1;
        armed     <= 1'b0;
        inj_cnt   <= '0;
      end else if (injecting && (state == IDLE || stop_now)) begin
        injecting <= 1'b0;
        shift     <= '0;
      end else if (injecting && rise) begin
        if (inj_cnt == SLOT_LAST) begin
          injecting <= 1'b0;
          shift     <= '0;
        end else begin
          shift   <= {shift[CODE_W-2:0], 1'b0};
          inj_cnt <= inj_cnt + SLOT_W'(1);
        end
      end
    end
  end

  // Registered outputs, one cycle behind the internal state.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_out   <= '0;
      previn_out <= 1'b0;
      ch_idx     <= '0;
      running    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      ctrl_out   <= {fadc, fch, started && slot_last, started && (slot == '0), fdata};
      previn_out <= injecting & shift[CODE_W-1];
      ch_idx     <= ch;
      running    <= (state != IDLE);
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_eareeg_seq_gen.sv
// Directed bench for eareeg_seq_gen (N_CH=4, CODE_W=8).
module tb_eareeg_seq_gen;
  localparam int N_CH = 4, CODE_W = 8, DIV_W = 16;

  logic              sys_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run_trig = 1'b0;
  logic              previn_trig = 1'b0;
  logic [CODE_W-1:0] previn_code = '0;
  logic [DIV_W-1:0]  half_div = '0;
  logic [2:0]        ch_count = '0;
  logic [4:0]        ctrl_out;
  logic              previn_out;
  logic [1:0]        ch_idx;
  logic              running;
  logic              frame_done;
  int checks = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  eareeg_seq_gen #(.N_CH(N_CH), .CODE_W(CODE_W), .DIV_W(DIV_W)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .run_trig(run_trig), .previn_trig(previn_trig),
    .previn_code(previn_code), .half_div(half_div), .ch_count(ch_count),
    .ctrl_out(ctrl_out), .previn_out(previn_out), .ch_idx(ch_idx),
    .running(running), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic pulse_run();
    @(negedge sys_clk); run_trig = 1'b1;
    repeat (4) @(negedge sys_clk);
    run_trig = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic pulse_previn(input logic [CODE_W-1:0] code);
    previn_code = code; previn_trig = 1'b1;
    repeat (4) @(negedge sys_clk);
    previn_trig = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    do begin @(negedge sys_clk); n++; end while (frame_done !== 1'b1 && n < 400);
    chk(tag, frame_done, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (running !== 1'b0 && n < 400) begin @(negedge sys_clk); n++; end
    chk(tag, running, 0);
  endtask

  // Start with a config, measure one frame: max ch_idx, frame length, fdata toggles.
  task automatic run_cfg(input string tag, input logic [DIV_W-1:0] hd, input logic [2:0] cc,
                         input int exp_max, input int exp_per, input int exp_tog);
    int max_ch = 0, fd_pos = 0, tog = 0;
    logic prev;
    half_div = hd; ch_count = cc;
    pulse_run();
    wait_frame({tag, "_first_fd"});
    prev = ctrl_out[0];
    for (int c = 1; c <= exp_per; c++) begin
      @(negedge sys_clk);
      if (int'(ch_idx) > max_ch) max_ch = int'(ch_idx);
      if (frame_done && fd_pos == 0) fd_pos = c;
      if (ctrl_out[0] != prev) tog++;
      prev = ctrl_out[0];
    end
    chk({tag, "_max_ch"}, max_ch, exp_max);
    chk({tag, "_frame_len"}, fd_pos, exp_per);
    chk({tag, "_fdata_tog"}, tog, exp_tog);
    pulse_run();
    wait_idle({tag, "_stop"});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, run_lat, loads, reads, rises, fchs, fds, fd_c, fall_c, n, seen;
    logic pf, pfc;
    logic [CODE_W-1:0] exp_code;

    // Reset with run_trig held high: outputs zero, and no start after release.
    run_trig = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_ctrl", ctrl_out, 0);
    chk("rst_previn", previn_out, 0);
    chk("rst_ch_idx", ch_idx, 0);
    chk("rst_running", running, 0);
    chk("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);
    chk("held_trig_no_start", running, 0);
    chk("held_trig_ctrl", ctrl_out, 0);
    run_trig = 1'b0;
    repeat (5) @(negedge sys_clk);

    // Start latency: 3 cycles sync/edge, 1 FSM, half_div+1 divider, 1 output register.
    half_div = 16'd1; ch_count = 3'd4;
    @(negedge sys_clk); run_trig = 1'b1;
    lat = 0; run_lat = 0;
    while (ctrl_out[0] !== 1'b1 && lat < 50) begin
      @(negedge sys_clk); lat++;
      if (lat == 4) run_trig = 1'b0;
      if (running === 1'b1 && run_lat == 0) run_lat = lat;
    end
    chk("start_running_lat", run_lat, 5);
    chk("start_fdata_lat", lat, 7);

    // One full frame at half_div=1, 4 channels.
    wait_frame("frame1_fd");
    loads = 0; reads = 0; rises = 0; fchs = 0; fds = 0;
    pf = ctrl_out[0]; pfc = ctrl_out[3];
    for (int c = 1; c <= 128; c++) begin
      @(negedge sys_clk);
      loads += int'(ctrl_out[1]);
      reads += int'(ctrl_out[2]);
      if (ctrl_out[0] && !pf) rises++;
      if (ctrl_out[3] != pfc) fchs++;
      fds += int'(frame_done);
      pf = ctrl_out[0]; pfc = ctrl_out[3];
    end
    chk("frame_load_cycles", loads, 16);
    chk("frame_read_cycles", reads, 16);
    chk("frame_fdata_rises", rises, 32);
    chk("frame_fch_toggles", fchs, 4);
    chk("frame_done_count", fds, 1);
    chk("frame_done_at_128", frame_done, 1);

    // Arm 8'hA5 mid-frame; a second edge during injection must be ignored.
    repeat (40) @(negedge sys_clk);
    pulse_previn(8'hA5);
    exp_code = 8'hA5;
    wait_frame("inj_fd");
    for (int c = 1; c <= 36; c++) begin
      @(negedge sys_clk);
      if (c == 10) begin previn_code = 8'hFF; previn_trig = 1'b1; end
      if (c == 14) previn_trig = 1'b0;
      if (c >= 2 && c <= 30 && (c - 2) % 4 == 0)
        chk($sformatf("inj_bit%0d", (c - 2) / 4), previn_out, exp_code[7 - (c - 2) / 4]);
      if (c == 34) chk("inj_tail", previn_out, 0);
    end
    wait_frame("inj_next_fd");
    repeat (2) @(negedge sys_clk);
    chk("no_rearm", previn_out, 0);

    // Stop mid-frame: frame completes once, then IDLE; a run edge in DRAIN is ignored.
    wait_frame("drain_sync_fd");
    fds = 0; fd_c = 0; fall_c = 0;
    for (int c = 1; c <= 250; c++) begin
      @(negedge sys_clk);
      if (c == 40 || c == 60) run_trig = 1'b1;
      if (c == 44 || c == 64) run_trig = 1'b0;
      if (frame_done) begin fds++; fd_c = c; end
      if (!running && fall_c == 0) fall_c = c;
    end
    chk("drain_fd_count", fds, 1);
    chk("drain_fd_pos", fd_c, 128);
    chk("drain_running_fall", fall_c, 129);
    chk("drain_idle_ctrl", ctrl_out, 0);
    chk("drain_idle_running", running, 0);
    chk("drain_idle_ch_idx", ch_idx, 0);

    // Channel-count clamping and half_div extremes.
    run_cfg("cc0", 16'd1, 3'd0, 3, 128, 64);
    run_cfg("cc7", 16'd1, 3'd7, 3, 128, 64);
    run_cfg("cc2", 16'd1, 3'd2, 1, 64, 32);
    run_cfg("hd0", 16'd0, 3'd4, 3, 64, 64);

    // Armed in IDLE, injection starts at first slot; reset mid-injection clears all.
    pulse_previn(8'hA5);
    repeat (10) @(negedge sys_clk);
    half_div = 16'd1; ch_count = 3'd4;
    pulse_run();
    n = 0;
    while (previn_out !== 1'b1 && n < 200) begin @(negedge sys_clk); n++; end
    chk("idle_arm_inject", previn_out, 1);
    chk("inject_on_load", ctrl_out[1], 1);
    repeat (6) @(negedge sys_clk);
    run_trig = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", ctrl_out, 0);
    chk("async_rst_previn", previn_out, 0);
    chk("async_rst_running", running, 0);
    chk("async_rst_ch_idx", ch_idx, 0);
    chk("async_rst_frame_done", frame_done, 0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (40) @(negedge sys_clk);
    chk("post_rst_running", running, 0);
    chk("post_rst_ctrl", ctrl_out, 0);
    run_trig = 1'b0;
    repeat (5) @(negedge sys_clk);
    pulse_run();
    seen = 0;
    repeat (80) begin
      @(negedge sys_clk);
      if (previn_out === 1'b1) seen = 1;
    end
    chk("rst_cleared_arm", seen, 0);
    chk("restart_running", running, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eareeg_seq_gen.md
EAREEG_SEQ_GEN -- requirements
Module: earEEG_seq_gen

Interface
REQ-001 SHALL have parameter N_CH, default 4, maximum channel count per frame (2..16).
REQ-002 SHALL have parameter CODE_W, default 8, PREVIN code width and slots per channel (4..32).
REQ-003 SHALL have parameter DIV_W, default 16, width of half-period divisor.
REQ-004 SHALL have port sys_clk  in  1  system clock.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port run_trig  in  1  asynchronous start/stop request; rising edge toggles run request.
REQ-007 SHALL have port previn_trig  in  1  asynchronous PREVIN request; rising edge arms code injection.
REQ-008 SHALL have port previn_code  in  CODE_W  code to inject, MSB first.
REQ-009 SHALL have port half_div  in  DIV_W  fdata half-period minus one, in sys_clk cycles.
REQ-010 SHALL have port ch_count  in  $clog2(N_CH)+1  active channels per frame.
REQ-011 SHALL have port ctrl_out  out  5  {fadc_g, fch_g, read_g, load_g, fdata_g}.
REQ-012 SHALL have port previn_out  out  1  serialized PREVIN bit.
REQ-013 SHALL have ports ch_idx  out  $clog2(N_CH)  current channel; running  out  1  sequencer active; frame_done  out  1  one-cycle pulse per completed frame.

Function
REQ-014 SHALL pass run_trig and previn_trig through 2-FF synchronizers, then rising-edge detect; detected edge = 1-cycle pulse, 3 cycles after input rise.
REQ-015 SHALL implement FSM IDLE, RUN, DRAIN; IDLE->RUN on run edge; RUN->DRAIN on run edge; DRAIN->IDLE at frame end; run edge in DRAIN ignored.
REQ-016 SHALL sample half_div and ch_count on IDLE->RUN only; ch_count 0 or >N_CH SHALL be treated as N_CH.
REQ-017 SHALL run divider counter 0..half_div; tick when count==half_div, then count restarts at 0; half_div=0 gives tick every cycle.
REQ-018 SHALL toggle fdata on each tick; fdata rising tick starts a slot; slot counter 0..CODE_W-1 advances per slot.
REQ-019 SHALL drive load_g high for whole of slot 0 and read_g high for whole of slot CODE_W-1.
REQ-020 SHALL advance ch_idx at slot wrap, 0..ch_count-1, and toggle fch_g at every slot wrap.
REQ-021 SHALL toggle fadc_g and pulse frame_done at ch_idx wrap (frame end: last slot of channel ch_count-1 completes).
REQ-022 SHALL latch previn_code into shift register on previn edge when injector idle; edge while injecting or armed SHALL be ignored.
REQ-023 SHALL begin injection at next slot 0 of channel 0; previn_out = shift MSB for one slot, shift left per slot, CODE_W slots total, then previn_out 0 and injector idle.
REQ-024 SHALL hold armed injection across IDLE; injection SHALL NOT start in DRAIN; mid-injection DRAIN completes injection only if frame end not reached, else truncates to 0.
REQ-025 SHALL register all outputs; ctrl_out, previn_out, ch_idx, frame_done lag internal state by exactly 1 cycle.
REQ-026 SHALL, in IDLE, hold divider, slot, ch_idx, ctrl_out at 0; running = 1 in RUN and DRAIN.
REQ-027 SHALL make first fdata rise of RUN occur half_div+1 cycles after FSM enters RUN.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear FSM to IDLE, all counters, synchronizers, shift register, armed flag, and all outputs to 0.
REQ-029 SHALL, on rst_n deassert, require a fresh run_trig rise to start; a trigger held high through reset SHALL NOT start the sequencer.

Verification
REQ-030 SHALL cover: N_CH=4, CODE_W=8, half_div=1, ch_count=4, run edge -> fdata period 4 cycles, load_g high 4 cycles per 32, frame_done every 128 cycles.
REQ-031 SHALL cover: previn_code=8'hA5 armed mid-frame -> previn_out 1,0,1,0,0,1,0,1 over slots 0..7 of next channel 0, then 0.
REQ-032 SHALL cover: second previn edge during injection of 8'hA5 -> ignored, no change to serialized bits.
REQ-033 SHALL cover: run edge mid-frame -> DRAIN, frame completes, frame_done pulses once, IDLE, ctrl_out 0.
REQ-034 SHALL cover: ch_count=0 and ch_count=7 -> ch_idx wraps at 3; half_div=0 -> fdata toggles every cycle.
REQ-035 SHALL cover: rst_n low mid-injection in RUN -> all outputs 0 same cycle, no resume after release.
